// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: pixel buffer, GRB reordering toward the RZ encoder, latch gap.
// Optional macro WS2812_BRIGHTNESS_EN adds the 8-bit 'bright' input for per-channel scaling.
module ws2812_frame_ctrl #(
    parameter int LED_NUM      = 8,
    parameter int ADDR_W       = 8,
    parameter int LATCH_CYCLES = 15000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              start,
    input  logic              loop_en,
    input  logic              tx_done,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]        bright,
`endif
    output logic [23:0]       rgb,
    output logic              tx_en,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LED_NUM - 1);
    localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [23:0]       rgb_q, rgb_d;
    logic              tx_en_q, tx_en_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [23:0]       buf_q [LED_NUM];

    logic [ADDR_W-1:0] rd_addr_s;
    logic [23:0]       rd_pix_s;
    logic [23:0]       load_pix_s;

`ifdef WS2812_BRIGHTNESS_EN
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] prod;
        prod = {9'd0, c} * ({9'd0, b} + 17'd1);
        return prod[15:8];
    endfunction
`endif

    // Pixel buffer: out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LED_NUM; i++) begin
            if (wr_en && (wr_addr == i[ADDR_W-1:0])) begin
                buf_q[i] <= wr_data;
            end
        end
    end

    // Asynchronous buffer read and GRB reorder of the pixel about to be loaded.
    always_comb begin
        rd_addr_s = (state_q == ST_SEND) ? (idx_q + ADDR_W'(1)) : {ADDR_W{1'b0}};
        rd_pix_s  = 24'h000000;
        for (int i = 0; i < LED_NUM; i++) begin
            rd_pix_s = (rd_addr_s == i[ADDR_W-1:0]) ? buf_q[i] : rd_pix_s;
        end
`ifdef WS2812_BRIGHTNESS_EN
        load_pix_s = {scale_ch(rd_pix_s[15:8], bright),
                      scale_ch(rd_pix_s[23:16], bright),
                      scale_ch(rd_pix_s[7:0], bright)};
`else
        load_pix_s = {rd_pix_s[15:8], rd_pix_s[23:16], rd_pix_s[7:0]};
`endif
    end

    // Next-state and output logic for the IDLE / SEND / LATCH sequencer.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        rgb_d        = rgb_q;
        tx_en_d      = tx_en_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEND;
                    idx_d   = {ADDR_W{1'b0}};
                    rgb_d   = load_pix_s;
                    tx_en_d = 1'b1;
                end else begin
                    tx_en_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_LATCH;
                        tx_en_d = 1'b0;
                        rgb_d   = 24'h000000;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                        rgb_d = load_pix_s;
                    end
                end else begin
                    tx_en_d = 1'b1;
                end
            end
            ST_LATCH: begin
                // frame_done is high for exactly one cycle before leaving LATCH.
                if (frame_done_q) begin
                    if (loop_en) begin
                        state_d = ST_SEND;
                        idx_d   = {ADDR_W{1'b0}};
                        rgb_d   = load_pix_s;
                        tx_en_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == CNT_END) begin
                    frame_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = {ADDR_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
                rgb_d   = 24'h000000;
                tx_en_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= {ADDR_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            rgb_q        <= 24'h000000;
            tx_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            rgb_q        <= rgb_d;
            tx_en_q      <= tx_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rgb        = rgb_q;
    assign tx_en      = tx_en_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
